// File: rtl/z88_slot_ctrl_if.sv
// Blink/Z80 memory bus between the CPU side (master) and the slot controller (slave).
interface z88_slot_ctrl_if #(
    parameter int AW = 22
);
    logic [AW-1:0] ma;
    logic          mrq_n;
    logic          roe_n;
    logic          wrb_n;
    logic [7:0]    cdo;
    logic [7:0]    cdi;
    logic          wait_n;

    modport master (output ma, mrq_n, roe_n, wrb_n, cdo, input cdi, wait_n);
    modport slave  (input ma, mrq_n, roe_n, wrb_n, cdo, output cdi, wait_n);
endinterface

// File: rtl/z88_slot_ctrl.sv
// Z88 memory-slot controller: slot decode, read mux, per-slot wait states, card-detect debounce.
// Optional write protection per slot when SLOT_WRPROT_EN is defined (adds cfg_wp / wp_err).
module z88_slot_ctrl #(
    parameter int NUM_SLOTS  = 4,
    parameter int SLOT_AW    = 20,
    parameter int WS_W       = 3,
    parameter int DEFAULT_WS = 0,
    parameter int DEB_W      = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cen,
    z88_slot_ctrl_if.slave                    bus,
    output logic [SLOT_AW-1:0]                slot_a,
    output logic [7:0]                        slot_di,
    input  logic [8*NUM_SLOTS-1:0]            slot_do,
    output logic [NUM_SLOTS-1:0]              slot_ce_n,
    output logic                              slot_oe_n,
    output logic                              slot_we_n,
    input  logic [NUM_SLOTS-2:0]              card_det,
    output logic [NUM_SLOTS-1:0]              card_present,
    output logic                              card_irq,
    input  logic                              irq_ack,
    input  logic                              cfg_we,
    input  logic [$clog2(NUM_SLOTS)-1:0]      cfg_slot,
`ifdef SLOT_WRPROT_EN
    input  logic                              cfg_wp,
    output logic                              wp_err,
`endif
    input  logic [WS_W-1:0]                   cfg_ws
);

    localparam int SW = $clog2(NUM_SLOTS);
    localparam logic [DEB_W-1:0] DEB_MAX = '1;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t                 state;
    logic [WS_W-1:0]        cnt;
    logic [WS_W-1:0]        ws [NUM_SLOTS];
    logic                   wait_q;
    logic [SW-1:0]          sel;
    logic                   acc;
    logic [NUM_SLOTS-1:1]   sync1;
    logic [NUM_SLOTS-1:1]   sync2;
    logic [NUM_SLOTS-1:1]   present_q;
    logic [NUM_SLOTS-1:1]   flip;
    logic [DEB_W-1:0]       deb_cnt [1:NUM_SLOTS-1];
    logic                   irq_q;

    assign sel          = bus.ma[SLOT_AW+SW-1:SLOT_AW];
    assign acc          = !bus.mrq_n && (!bus.roe_n || !bus.wrb_n);
    assign card_present = {present_q, 1'b1};
    assign slot_a       = bus.ma[SLOT_AW-1:0];
    assign slot_di      = bus.cdo;
    assign slot_oe_n    = bus.roe_n | !acc;
    assign bus.wait_n   = wait_q;
    assign card_irq     = irq_q;

    always_comb begin
        slot_ce_n = '1;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (acc && sel == SW'(s) && card_present[s])
                slot_ce_n[s] = 1'b0;
        end
    end

    // Empty slots float high on the data bus, so unpopulated reads see 8'hFF.
    always_comb begin
        bus.cdi = 8'hFF;
        if (acc && !bus.roe_n && card_present[sel])
            bus.cdi = slot_do[{sel, 3'b000} +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            wait_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        cnt <= ws[sel];
                        if (ws[sel] == '0) begin
                            state <= HOLD;
                        end else begin
                            state  <= WAIT;
                            wait_q <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (!acc) begin
                        state  <= IDLE;
                        wait_q <= 1'b1;
                    end else if (cen) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == WS_W'(1)) begin
                            state  <= HOLD;
                            wait_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!acc)
                        state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    wait_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SLOTS; s++)
                ws[s] <= WS_W'(DEFAULT_WS);
        end else if (cfg_we) begin
            ws[cfg_slot] <= cfg_ws;
        end
    end

    always_comb begin
        flip = '0;
        for (int s = 1; s < NUM_SLOTS; s++)
            flip[s] = (sync2[s] != present_q[s]) && (deb_cnt[s] == DEB_MAX);
    end

    // Presence only flips after the synchronised detect disagrees for 2^DEB_W straight cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            present_q <= '0;
            irq_q     <= 1'b0;
            for (int s = 1; s < NUM_SLOTS; s++)
                deb_cnt[s] <= '0;
        end else begin
            sync1     <= card_det;
            sync2     <= sync1;
            present_q <= present_q ^ flip;
            for (int s = 1; s < NUM_SLOTS; s++) begin
                if (sync2[s] == present_q[s] || flip[s])
                    deb_cnt[s] <= '0;
                else
                    deb_cnt[s] <= deb_cnt[s] + 1'b1;
            end
            if (|flip)
                irq_q <= 1'b1;
            else if (irq_ack)
                irq_q <= 1'b0;
        end
    end

`ifdef SLOT_WRPROT_EN
    logic [NUM_SLOTS-1:0] wp;

    assign slot_we_n = bus.wrb_n | !acc | wp[sel];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp     <= '0;
            wp_err <= 1'b0;
        end else begin
            if (cfg_we)
                wp[cfg_slot] <= cfg_wp;
            wp_err <= (state == IDLE) && acc && !bus.wrb_n && wp[sel];
        end
    end
`else
    assign slot_we_n = bus.wrb_n | !acc;
`endif

endmodule

// File: tb/tb_z88_slot_ctrl.sv
// Self-checking bench for z88_slot_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_z88_slot_ctrl;

    localparam int NUM_SLOTS  = 4;
    localparam int SLOT_AW    = 20;
    localparam int WS_W       = 3;
    localparam int DEFAULT_WS = 0;
    localparam int DEB_W      = 10;
    localparam int SW         = 2;
    localparam int AW         = SLOT_AW + SW;
    localparam int DEB_LEN    = 1 << DEB_W;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     cen;
    logic [SLOT_AW-1:0]       slot_a;
    logic [7:0]               slot_di;
    logic [8*NUM_SLOTS-1:0]   slot_do;
    logic [NUM_SLOTS-1:0]     slot_ce_n;
    logic                     slot_oe_n;
    logic                     slot_we_n;
    logic [NUM_SLOTS-2:0]     card_det;
    logic [NUM_SLOTS-1:0]     card_present;
    logic                     card_irq;
    logic                     irq_ack;
    logic                     cfg_we;
    logic [SW-1:0]            cfg_slot;
    logic [WS_W-1:0]          cfg_ws;
`ifdef SLOT_WRPROT_EN
    logic                     cfg_wp;
    logic                     wp_err;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    z88_slot_ctrl_if #(.AW(AW)) bus ();

    z88_slot_ctrl #(
        .NUM_SLOTS(NUM_SLOTS), .SLOT_AW(SLOT_AW), .WS_W(WS_W),
        .DEFAULT_WS(DEFAULT_WS), .DEB_W(DEB_W)
    ) dut (
        .clk(clk), .reset(reset), .cen(cen), .bus(bus),
        .slot_a(slot_a), .slot_di(slot_di), .slot_do(slot_do),
        .slot_ce_n(slot_ce_n), .slot_oe_n(slot_oe_n), .slot_we_n(slot_we_n),
        .card_det(card_det), .card_present(card_present), .card_irq(card_irq),
        .irq_ack(irq_ack), .cfg_we(cfg_we), .cfg_slot(cfg_slot),
`ifdef SLOT_WRPROT_EN
        .cfg_wp(cfg_wp), .wp_err(wp_err),
`endif
        .cfg_ws(cfg_ws)
    );

    always #5 clk = ~clk;

    // Behavioural model: access bookkeeping, wait ticks left, presence and per-slot config.
    logic [NUM_SLOTS-1:0] m_pres;
    logic [NUM_SLOTS-1:1] m_d1, m_d2;
    int                   m_run [NUM_SLOTS];
    int                   m_ws  [NUM_SLOTS];
    bit                   m_wp  [NUM_SLOTS];
    bit                   m_irq, m_busy, m_wp_err, m_flip;
    int                   m_rem, m_sel;
    bit                   m_acc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pres = 4'b0001; m_d1 = '0; m_d2 = '0;
            m_irq = 0; m_busy = 0; m_rem = 0; m_wp_err = 0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                m_run[s] = 0; m_ws[s] = DEFAULT_WS; m_wp[s] = 0;
            end
        end else begin
            m_acc = !bus.mrq_n && (!bus.roe_n || !bus.wrb_n);
            m_sel = int'(bus.ma[AW-1:SLOT_AW]);
            m_wp_err = 0;
            if (!m_acc) begin
                m_busy = 0; m_rem = 0;
            end else if (!m_busy) begin
                m_busy = 1; m_rem = m_ws[m_sel];
                m_wp_err = m_wp[m_sel] && !bus.wrb_n;
            end else if (m_rem > 0 && cen) begin
                m_rem = m_rem - 1;
            end
            m_flip = 0;
            for (int s = 1; s < NUM_SLOTS; s++) begin
                if (m_d2[s] != m_pres[s]) begin
                    m_run[s] = m_run[s] + 1;
                    if (m_run[s] == DEB_LEN) begin
                        m_pres[s] = !m_pres[s]; m_run[s] = 0; m_flip = 1;
                    end
                end else begin
                    m_run[s] = 0;
                end
            end
            m_d2 = m_d1; m_d1 = card_det;
            if (m_flip) m_irq = 1;
            else if (irq_ack) m_irq = 0;
            if (cfg_we) begin
                m_ws[cfg_slot] = int'(cfg_ws);
`ifdef SLOT_WRPROT_EN
                m_wp[cfg_slot] = cfg_wp;
`endif
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && chk_en) begin
            logic                 acc;
            int                   sel;
            logic [NUM_SLOTS-1:0] exp_ce;
            logic [7:0]           exp_cdi;
            logic                 exp_we;
            acc = !bus.mrq_n && (!bus.roe_n || !bus.wrb_n);
            sel = int'(bus.ma[AW-1:SLOT_AW]);
            for (int s = 0; s < NUM_SLOTS; s++)
                exp_ce[s] = !(acc && sel == s && m_pres[s]);
            exp_cdi = (acc && !bus.roe_n && m_pres[sel]) ? slot_do[sel*8 +: 8] : 8'hFF;
            exp_we  = bus.wrb_n || !acc || m_wp[sel];
            check_output("slot_ce_n", 32'(slot_ce_n), 32'(exp_ce));
            check_output("cdi", 32'(bus.cdi), 32'(exp_cdi));
            check_output("slot_oe_n", 32'(slot_oe_n), 32'(bus.roe_n || !acc));
            check_output("slot_we_n", 32'(slot_we_n), 32'(exp_we));
            check_output("slot_a", 32'(slot_a), 32'(bus.ma[SLOT_AW-1:0]));
            check_output("slot_di", 32'(slot_di), 32'(bus.cdo));
            check_output("wait_n", 32'(bus.wait_n), 32'(!(m_busy && m_rem > 0)));
            check_output("card_present", 32'(card_present), 32'(m_pres));
            check_output("card_irq", 32'(card_irq), 32'(m_irq));
`ifdef SLOT_WRPROT_EN
            check_output("wp_err", 32'(wp_err), 32'(m_wp_err));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic [AW-1:0] a, input logic mrq, input logic rd, input logic wr);
        bus.ma = a; bus.mrq_n = mrq; bus.roe_n = rd; bus.wrb_n = wr;
    endtask

    initial begin
        int ticks;
        int left;
        reset = 1'b1; cen = 1'b0; slot_do = '0; card_det = '0; irq_ack = 1'b0;
        cfg_we = 1'b0; cfg_slot = '0; cfg_ws = '0; bus.cdo = 8'h00;
`ifdef SLOT_WRPROT_EN
        cfg_wp = 1'b0;
`endif
        apply_stimulus('0, 1'b1, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        chk_en = 1;
        #1;
        check_output("reset card_present", 32'(card_present), 32'h1);
        check_output("reset wait_n", 32'(bus.wait_n), 32'h1);
        check_output("reset slot_ce_n", 32'(slot_ce_n), 32'hF);

        step();
        apply_stimulus(22'h300000, 1'b0, 1'b0, 1'b1);
        #1 check_output("empty slot cdi", 32'(bus.cdi), 32'hFF);
        step();
        apply_stimulus('0, 1'b1, 1'b1, 1'b1);

        step();
        slot_do = 32'h1122_33A5;
        apply_stimulus(22'h012345, 1'b0, 1'b0, 1'b1);
        #1;
        check_output("slot0 ce_n", 32'(slot_ce_n), 32'hE);
        check_output("slot0 slot_a", 32'(slot_a), 32'h12345);
        check_output("slot0 cdi", 32'(bus.cdi), 32'hA5);
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("slot0 wait_n", 32'(bus.wait_n), 32'h1);
        end
        apply_stimulus('0, 1'b1, 1'b1, 1'b1);

        // Insert card in slot 2 and give it three wait states.
        card_det[1] = 1'b1;
        repeat (1100) step();
        check_output("slot2 present", 32'(card_present), 32'h5);
        check_output("slot2 irq", 32'(card_irq), 32'h1);
        irq_ack = 1'b1; cfg_we = 1'b1; cfg_slot = 2'd2; cfg_ws = 3'd3;
        step();
        irq_ack = 1'b0; cfg_we = 1'b0;
        #1 check_output("slot2 irq ack", 32'(card_irq), 32'h0);
        step();
        apply_stimulus(22'h200010, 1'b0, 1'b0, 1'b1);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            cen = (i % 4 == 3);
            #1 if (!bus.wait_n && cen) ticks++;
            step();
        end
        cen = 1'b0;
        #1;
        check_output("slot2 wait ticks", 32'(ticks), 32'd3);
        check_output("slot2 hold wait_n", 32'(bus.wait_n), 32'h1);
        apply_stimulus(22'h200010, 1'b1, 1'b1, 1'b1);
        step();

        card_det[0] = 1'b1;
        repeat (500) step();
        card_det[0] = 1'b0;
        repeat (600) step();
        check_output("glitch present", 32'(card_present), 32'h5);
        card_det[0] = 1'b1;
        repeat (DEB_LEN + 1) step();
        check_output("debounce edge-1", 32'(card_present[1]), 32'h0);
        step();
        check_output("debounce present", 32'(card_present[1]), 32'h1);
        check_output("debounce irq", 32'(card_irq), 32'h1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        #1 check_output("debounce irq ack", 32'(card_irq), 32'h0);

`ifdef SLOT_WRPROT_EN
        cfg_we = 1'b1; cfg_slot = 2'd1; cfg_ws = 3'd0; cfg_wp = 1'b1;
        step();
        cfg_we = 1'b0; cfg_wp = 1'b0;
        apply_stimulus(22'h100000, 1'b0, 1'b1, 1'b0);
        #1;
        check_output("wp ce_n", 32'(slot_ce_n[1]), 32'h0);
        check_output("wp we_n", 32'(slot_we_n), 32'h1);
        step();
        check_output("wp_err pulse", 32'(wp_err), 32'h1);
        step();
        check_output("wp_err single", 32'(wp_err), 32'h0);
        apply_stimulus('0, 1'b1, 1'b1, 1'b1);
        cfg_we = 1'b1; cfg_slot = 2'd1; cfg_ws = 3'd0; cfg_wp = 1'b0;
        step();
        cfg_we = 1'b0;
`endif

        // Random traffic phase, checked each cycle against the model.
        left = 0;
        for (int i = 0; i < 6000; i++) begin
            if (left > 0) begin
                left--;
                if (left == 0) apply_stimulus(bus.ma, 1'b1, 1'b1, 1'b1);
            end else if ($urandom_range(0, 2) != 0) begin
                logic rd;
                rd = $urandom_range(0, 1) == 1;
                apply_stimulus(AW'($urandom), 1'b0, !rd, rd);
                left = $urandom_range(1, 14);
            end
            cen = ($urandom_range(0, 2) == 0);
            slot_do = $urandom;
            bus.cdo = 8'($urandom);
            cfg_we = ($urandom_range(0, 9) == 0);
            cfg_slot = SW'($urandom);
            cfg_ws = WS_W'($urandom);
`ifdef SLOT_WRPROT_EN
            cfg_wp = ($urandom_range(0, 3) == 0);
`endif
            irq_ack = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0)
                card_det[$urandom_range(0, NUM_SLOTS-2)] ^= 1'b1;
            step();
        end
        cfg_we = 1'b0; irq_ack = 1'b0;
        apply_stimulus('0, 1'b1, 1'b1, 1'b1);
        step();

        // Reset while counting down five wait states on slot 0.
        cfg_we = 1'b1; cfg_slot = 2'd0; cfg_ws = 3'd5;
        step();
        cfg_we = 1'b0; cen = 1'b0;
        apply_stimulus(22'h000100, 1'b0, 1'b0, 1'b1);
        step();
        step();
        check_output("midwait wait_n low", 32'(bus.wait_n), 32'h0);
        reset = 1'b1;
        #1 check_output("async reset wait_n", 32'(bus.wait_n), 32'h1);
        apply_stimulus('0, 1'b1, 1'b1, 1'b1);
        step();
        reset = 1'b0;
        #1 check_output("post reset present", 32'(card_present), 32'h1);
        step();
        cen = 1'b1;
        apply_stimulus(22'h000100, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            check_output("post reset ws", 32'(bus.wait_n), 32'h1);
        end
        apply_stimulus('0, 1'b1, 1'b1, 1'b1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
